// File: rtl/bp_cce_spec_resolve.sv
// bp_cce_spec_resolve: resolves memory responses against the speculation-bit store.
// Define BP_CCE_SPEC_RESOLVE_STATS_EN to build the squash / fwd_mod event counters.
module bp_cce_spec_resolve #(
    parameter int addr_width_p = 40,
    parameter int cnt_width_p = 16,
    localparam int state_width_lp = 3,
    localparam int spec_width_lp = 3 + state_width_lp
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      mem_resp_v_i,
    input  logic [addr_width_p-1:0]   mem_resp_addr_i,
    input  logic                      mem_resp_bypass_hash_i,
    output logic                      mem_resp_ready_o,
    output logic                      spec_r_v_o,
    output logic [addr_width_p-1:0]   spec_r_addr_o,
    output logic                      spec_r_bypass_hash_o,
    input  logic [spec_width_lp-1:0]  spec_i,
    output logic                      spec_w_v_o,
    output logic [addr_width_p-1:0]   spec_w_addr_o,
    output logic                      spec_w_bypass_hash_o,
    output logic                      spec_w_spec_v_o,
    output logic                      spec_w_squash_v_o,
    output logic                      spec_w_fwd_mod_v_o,
    output logic                      spec_w_state_v_o,
    output logic [spec_width_lp-1:0]  spec_w_o,
    output logic                      resolve_v_o,
    input  logic                      resolve_yumi_i,
    output logic [addr_width_p-1:0]   resolve_addr_o,
    output logic [1:0]                resolve_action_o,
    output logic [state_width_lp-1:0] resolve_state_o,
    output logic [cnt_width_p-1:0]    squash_cnt_o,
    output logic [cnt_width_p-1:0]    fwd_mod_cnt_o
);

    typedef struct packed {
        logic                      spec;
        logic                      squash;
        logic                      fwd_mod;
        logic [state_width_lp-1:0] state;
    } bp_cce_spec_s;

    typedef enum logic [1:0] {
        READY,
        LOOKUP,
        CLEAR,
        SEND
    } state_e;

    localparam logic [1:0] act_normal  = 2'b00;
    localparam logic [1:0] act_squash  = 2'b01;
    localparam logic [1:0] act_fwd_mod = 2'b10;

    state_e                    state_q, state_n;
    logic [addr_width_p-1:0]   addr_q;
    logic                      bypass_q;
    logic [1:0]                action_q, action_n;
    logic [state_width_lp-1:0] coh_q, coh_n;
    bp_cce_spec_s              spec_rd;
    logic                      accept;

    assign spec_rd = spec_i;
    assign accept  = mem_resp_v_i & mem_resp_ready_o;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= READY;
            addr_q   <= '0;
            bypass_q <= 1'b0;
            action_q <= act_normal;
            coh_q    <= '0;
        end else begin
            state_q <= state_n;
            if (accept) begin
                addr_q   <= mem_resp_addr_i;
                bypass_q <= mem_resp_bypass_hash_i;
            end
            if (state_q == LOOKUP) begin
                action_q <= action_n;
                coh_q    <= coh_n;
            end
        end
    end

    // Squash takes priority over fwd_mod when both are flagged.
    always_comb begin
        state_n            = state_q;
        action_n           = act_normal;
        coh_n              = '0;
        mem_resp_ready_o   = 1'b0;
        spec_r_v_o         = 1'b0;
        spec_w_v_o         = 1'b0;
        spec_w_spec_v_o    = 1'b0;
        spec_w_squash_v_o  = 1'b0;
        spec_w_fwd_mod_v_o = 1'b0;
        resolve_v_o        = 1'b0;
        unique case (state_q)
            READY: begin
                mem_resp_ready_o = 1'b1;
                if (mem_resp_v_i) state_n = LOOKUP;
            end
            LOOKUP: begin
                spec_r_v_o = 1'b1;
                if (!spec_rd.spec) begin
                    state_n = SEND;
                end else begin
                    state_n = CLEAR;
                    if (spec_rd.squash) begin
                        action_n = act_squash;
                    end else if (spec_rd.fwd_mod) begin
                        action_n = act_fwd_mod;
                        coh_n    = spec_rd.state;
                    end
                end
            end
            CLEAR: begin
                spec_w_v_o         = 1'b1;
                spec_w_spec_v_o    = 1'b1;
                spec_w_squash_v_o  = 1'b1;
                spec_w_fwd_mod_v_o = 1'b1;
                state_n            = SEND;
            end
            SEND: begin
                resolve_v_o = 1'b1;
                if (resolve_yumi_i) state_n = READY;
            end
        endcase
    end

    assign spec_r_addr_o        = addr_q;
    assign spec_r_bypass_hash_o = bypass_q;
    assign spec_w_addr_o        = addr_q;
    assign spec_w_bypass_hash_o = bypass_q;
    assign spec_w_state_v_o     = 1'b0;
    assign spec_w_o             = '0;
    assign resolve_addr_o       = addr_q;
    assign resolve_action_o     = action_q;
    assign resolve_state_o      = coh_q;

`ifdef BP_CCE_SPEC_RESOLVE_STATS_EN
    logic [cnt_width_p-1:0] squash_cnt_q, fwd_mod_cnt_q;
    logic                   enter_clear;

    assign enter_clear = (state_q == LOOKUP) && (state_n == CLEAR);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            squash_cnt_q  <= '0;
            fwd_mod_cnt_q <= '0;
        end else if (enter_clear) begin
            if (action_n == act_squash && !(&squash_cnt_q))
                squash_cnt_q <= squash_cnt_q + cnt_width_p'(1);
            if (action_n == act_fwd_mod && !(&fwd_mod_cnt_q))
                fwd_mod_cnt_q <= fwd_mod_cnt_q + cnt_width_p'(1);
        end
    end

    assign squash_cnt_o  = squash_cnt_q;
    assign fwd_mod_cnt_o = fwd_mod_cnt_q;
`else
    assign squash_cnt_o  = '0;
    assign fwd_mod_cnt_o = '0;
`endif

    a_yumi_in_send: assert property (
        @(posedge clk_i) disable iff (reset_i) resolve_yumi_i |-> resolve_v_o
    );

endmodule

// File: tb/tb_bp_cce_spec_resolve.sv
// Randomized bench for bp_cce_spec_resolve with a spec-store model and outcome predictor.
// Counter expectations follow BP_CCE_SPEC_RESOLVE_STATS_EN.
module tb_bp_cce_spec_resolve;

    localparam int AW = 8;
    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    typedef struct packed {
        logic       spec;
        logic       squash;
        logic       fwd_mod;
        logic [2:0] state;
    } spec_t;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          mem_resp_v_i;
    logic [AW-1:0] mem_resp_addr_i;
    logic          mem_resp_bypass_hash_i;
    logic          mem_resp_ready_o;
    logic          spec_r_v_o;
    logic [AW-1:0] spec_r_addr_o;
    logic          spec_r_bypass_hash_o;
    logic [5:0]    spec_i;
    logic          spec_w_v_o;
    logic [AW-1:0] spec_w_addr_o;
    logic          spec_w_bypass_hash_o;
    logic          spec_w_spec_v_o;
    logic          spec_w_squash_v_o;
    logic          spec_w_fwd_mod_v_o;
    logic          spec_w_state_v_o;
    logic [5:0]    spec_w_o;
    logic          resolve_v_o;
    logic          resolve_yumi_i;
    logic [AW-1:0] resolve_addr_o;
    logic [1:0]    resolve_action_o;
    logic [2:0]    resolve_state_o;
    logic [CW-1:0] squash_cnt_o;
    logic [CW-1:0] fwd_mod_cnt_o;

    int checks = 0;
    int errors = 0;

    spec_t      store [16];
    spec_t      model [16];
    logic       seed_v;
    logic [3:0] seed_idx;
    spec_t      seed_val;
    logic [CW-1:0] exp_sq, exp_fm;

    bp_cce_spec_resolve #(.addr_width_p(AW), .cnt_width_p(CW)) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .mem_resp_v_i(mem_resp_v_i),
        .mem_resp_addr_i(mem_resp_addr_i),
        .mem_resp_bypass_hash_i(mem_resp_bypass_hash_i),
        .mem_resp_ready_o(mem_resp_ready_o),
        .spec_r_v_o(spec_r_v_o),
        .spec_r_addr_o(spec_r_addr_o),
        .spec_r_bypass_hash_o(spec_r_bypass_hash_o),
        .spec_i(spec_i),
        .spec_w_v_o(spec_w_v_o),
        .spec_w_addr_o(spec_w_addr_o),
        .spec_w_bypass_hash_o(spec_w_bypass_hash_o),
        .spec_w_spec_v_o(spec_w_spec_v_o),
        .spec_w_squash_v_o(spec_w_squash_v_o),
        .spec_w_fwd_mod_v_o(spec_w_fwd_mod_v_o),
        .spec_w_state_v_o(spec_w_state_v_o),
        .spec_w_o(spec_w_o),
        .resolve_v_o(resolve_v_o),
        .resolve_yumi_i(resolve_yumi_i),
        .resolve_addr_o(resolve_addr_o),
        .resolve_action_o(resolve_action_o),
        .resolve_state_o(resolve_state_o),
        .squash_cnt_o(squash_cnt_o),
        .fwd_mod_cnt_o(fwd_mod_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] idx(input logic [AW-1:0] a, input logic b);
        return b ? a[3:0] : (a[3:0] ^ a[7:4]);
    endfunction

    // Store answers reads in the same cycle; junk when no read is issued.
    always_comb begin
        spec_i = 6'h3f;
        if (spec_r_v_o) spec_i = store[idx(spec_r_addr_o, spec_r_bypass_hash_o)];
    end

    always @(posedge clk) begin
        if (seed_v) begin
            store[seed_idx] <= seed_val;
        end else if (spec_w_v_o) begin
            if (spec_w_spec_v_o)
                store[idx(spec_w_addr_o, spec_w_bypass_hash_o)].spec <= spec_w_o[5];
            if (spec_w_squash_v_o)
                store[idx(spec_w_addr_o, spec_w_bypass_hash_o)].squash <= spec_w_o[4];
            if (spec_w_fwd_mod_v_o)
                store[idx(spec_w_addr_o, spec_w_bypass_hash_o)].fwd_mod <= spec_w_o[3];
            if (spec_w_state_v_o)
                store[idx(spec_w_addr_o, spec_w_bypass_hash_o)].state <= spec_w_o[2:0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic seed(input logic [3:0] i, input spec_t v);
        seed_v   = 1'b1;
        seed_idx = i;
        seed_val = v;
        model[i] = v;
        @(negedge clk);
        seed_v = 1'b0;
    endtask

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CMAX) ? c : c + 1'b1;
    endfunction

    task automatic chk_cnt(input string tag);
        chk({tag, "_sq_cnt"}, 32'(squash_cnt_o), 32'(exp_sq));
        chk({tag, "_fm_cnt"}, 32'(fwd_mod_cnt_o), 32'(exp_fm));
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_txn(input logic [AW-1:0] a, input logic b, input int hold);
        logic [3:0] i;
        spec_t      e;
        logic [1:0] ea;
        logic [2:0] es;
        i  = idx(a, b);
        e  = model[i];
        ea = 2'd0;
        es = 3'd0;
        if (e.spec && e.squash) ea = 2'd1;
        else if (e.spec && e.fwd_mod) begin
            ea = 2'd2;
            es = e.state;
        end
        if (e.spec) begin
            model[i].spec    = 1'b0;
            model[i].squash  = 1'b0;
            model[i].fwd_mod = 1'b0;
        end
`ifdef BP_CCE_SPEC_RESOLVE_STATS_EN
        if (ea == 2'd1) exp_sq = sat_inc(exp_sq);
        if (ea == 2'd2) exp_fm = sat_inc(exp_fm);
`endif
        chk("idle_ready", 32'(mem_resp_ready_o), 1);
        mem_resp_v_i           = 1'b1;
        mem_resp_addr_i        = a;
        mem_resp_bypass_hash_i = b;
        @(negedge clk);
        mem_resp_v_i           = 1'b0;
        mem_resp_addr_i        = AW'($urandom);
        mem_resp_bypass_hash_i = 1'($urandom);
        chk("lk_r_v", 32'(spec_r_v_o), 1);
        chk("lk_r_addr", 32'(spec_r_addr_o), 32'(a));
        chk("lk_r_byp", 32'(spec_r_bypass_hash_o), 32'(b));
        chk("lk_w_v", 32'(spec_w_v_o), 0);
        chk("lk_res_v", 32'(resolve_v_o), 0);
        chk("lk_ready", 32'(mem_resp_ready_o), 0);
        if (e.spec) begin
            @(negedge clk);
            chk("cl_w_v", 32'(spec_w_v_o), 1);
            chk("cl_w_addr", 32'(spec_w_addr_o), 32'(a));
            chk("cl_w_byp", 32'(spec_w_bypass_hash_o), 32'(b));
            chk("cl_w_en", 32'({spec_w_spec_v_o, spec_w_squash_v_o,
                                spec_w_fwd_mod_v_o, spec_w_state_v_o}), 32'hE);
            chk("cl_w_data", 32'(spec_w_o), 0);
            chk("cl_r_v", 32'(spec_r_v_o), 0);
            chk("cl_res_v", 32'(resolve_v_o), 0);
        end
        @(negedge clk);
        for (int h = 0; h <= hold; h++) begin
            chk("sd_res_v", 32'(resolve_v_o), 1);
            chk("sd_addr", 32'(resolve_addr_o), 32'(a));
            chk("sd_action", 32'(resolve_action_o), 32'(ea));
            chk("sd_state", 32'(resolve_state_o), 32'(es));
            chk("sd_w_v", 32'(spec_w_v_o), 0);
            chk("sd_ready", 32'(mem_resp_ready_o), 0);
            chk_cnt("sd");
            if (h < hold) @(negedge clk);
        end
        resolve_yumi_i = 1'b1;
        @(negedge clk);
        resolve_yumi_i = 1'b0;
        chk("store_entry", 32'(store[i]), 32'(model[i]));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i                = 1'b1;
        mem_resp_v_i           = 1'b0;
        mem_resp_addr_i        = '0;
        mem_resp_bypass_hash_i = 1'b0;
        resolve_yumi_i         = 1'b0;
        seed_v                 = 1'b0;
        seed_idx               = '0;
        seed_val               = '0;
        exp_sq                 = '0;
        exp_fm                 = '0;
        #1;
        chk("rst_ready", 32'(mem_resp_ready_o), 1);
        chk("rst_outs", 32'({spec_r_v_o, spec_w_v_o, resolve_v_o}), 0);
        chk("rst_res", 32'({resolve_addr_o, resolve_action_o, resolve_state_o}), 0);
        chk_cnt("rst");
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        for (int k = 0; k < 16; k++) seed(4'(k), spec_t'($urandom));

        // normal: spec clear, other fields ignored
        seed(idx(8'h80, 1'b0), spec_t'(6'b011101));
        run_txn(8'h80, 1'b0, 0);
        // squash wins over fwd_mod
        seed(idx(8'h21, 1'b0), spec_t'(6'b111010));
        run_txn(8'h21, 1'b0, 1);
        // fwd_mod with state, long stall on yumi
        seed(idx(8'h47, 1'b0), spec_t'(6'b101011));
        run_txn(8'h47, 1'b0, 5);
        // back-to-back with no idle gap
        seed(idx(8'h10, 1'b0), spec_t'(6'b101110));
        seed(idx(8'h12, 1'b0), spec_t'(6'b110000));
        run_txn(8'h10, 1'b0, 0);
        run_txn(8'h12, 1'b0, 0);
        run_txn(8'h80, 1'b0, 0);

        // reset during the clear cycle
        seed(idx(8'h5a, 1'b0), spec_t'(6'b110001));
        mem_resp_v_i    = 1'b1;
        mem_resp_addr_i = 8'h5a;
        @(negedge clk);
        mem_resp_v_i = 1'b0;
        @(negedge clk);
        chk("rc_w_v_pre", 32'(spec_w_v_o), 1);
        reset_i = 1'b1;
        #1;
        chk("rc_w_v_drop", 32'(spec_w_v_o), 0);
        chk("rc_res_v", 32'(resolve_v_o), 0);
        exp_sq = '0;
        exp_fm = '0;
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        chk("rc_ready", 32'(mem_resp_ready_o), 1);
        chk("rc_res_v2", 32'(resolve_v_o), 0);
        chk_cnt("rc");
        @(negedge clk);
        chk("rc_store", 32'(store[idx(8'h5a, 1'b0)]), 32'(model[idx(8'h5a, 1'b0)]));

        // bypass path and counter saturation
        for (int k = 0; k < (1 << CW) + 2; k++) begin
            seed(idx(8'h35, 1'b1), spec_t'(6'b110000 | 6'($urandom_range(0, 15))));
            run_txn(8'h35, 1'b1, 0);
        end
        chk_cnt("sat");

        for (int n = 0; n < 80; n++) begin
            logic [AW-1:0] a;
            logic          b;
            a = AW'($urandom);
            b = 1'($urandom);
            if ($urandom_range(0, 1) == 1) seed(idx(a, b), spec_t'($urandom));
            run_txn(a, b, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
